uart_rx: RTL and testbench

//  Receive side of the project UART: 8N1 serial frames on rx_bit_i become parallel words in a receive FIFO.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_fifo.sv | 39 +++
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types, line levels and baud divisor helper
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic START_BIT = 1'b0;
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous first-word fall-through FIFO, head reads as zero when empty
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wen_i,
  input  logic             ren_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic push, pop;
  assign pop = ren_i && !empty_o;
  assign push = wen_i && (!full_o || pop);
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign dout_o = empty_o ? '0 : mem[rd_q];
  // storage array, contents are don't-care until written
  always_ff @(posedge clk_i)
    if (push) mem[wr_q] <= din_i;
  // pointers wrap naturally at a power-of-two depth; a pop frees room for a same-cycle push
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver into a FIFO; define UART_RX_FRAME_ERR_EN to check the stop bit and add frame_err_o
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_ren_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overrun_o,
  output logic                  busy_o
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                  frame_err_o
`endif
);
  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] TOP_BIT = IW'(DATA_WIDTH - 1);
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic rx_meta, rx_s, push;
`ifdef UART_RX_FRAME_ERR_EN
  logic ferr;
`endif
  assign busy_o = state_q != IDLE;
  // two-flop synchronizer for the asynchronous line, preset to the idle level
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) {rx_s, rx_meta} <= 2'b11;
    else {rx_s, rx_meta} <= {rx_meta, rx_bit_i};
  // FSM state, baud counter, bit index and shift register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
    end
  // frame sequencing: half a bit to the start-bit centre, then whole bits; leave STOP at its centre
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    sh_d = sh_q;
    push = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_en_i && rx_s == START_BIT) state_d = START;
      end
      START:
        if (cnt_q == HALF) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_s == START_BIT ? DATA : IDLE;
        end
      DATA:
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d = {rx_s, sh_q[DATA_WIDTH-1:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == TOP_BIT) state_d = STOP;
        end
      STOP:
        if (cnt_q == LAST) begin
          cnt_d = '0;
          state_d = IDLE;
`ifdef UART_RX_FRAME_ERR_EN
          push = rx_s == STOP_BIT;
          ferr = rx_s != STOP_BIT;
`else
          push = 1'b1;
`endif
        end
      default: state_d = IDLE;
    endcase
  end
  // sticky overrun: a completed frame found the FIFO full with no pop to make room
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) overrun_o <= 1'b0;
    else overrun_o <= overrun_o | (push && full_o && !rx_ren_i);
`ifdef UART_RX_FRAME_ERR_EN
  // single-cycle pulse for a frame whose stop bit sampled low
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) frame_err_o <= 1'b0;
    else frame_err_o <= ferr;
`endif
  uart_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wen_i  (push),
    .ren_i  (rx_ren_i),
    .din_i  (sh_q),
    .dout_o (dout_o),
    .empty_o(empty_o),
    .full_o (full_o)
  );
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a queue model of the receive FIFO
module tb_uart_rx;
  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int BD = CLK_FREQ / BAUD_RATE;
  localparam int DEPTH = 16;
`ifdef UART_RX_FRAME_ERR_EN
  localparam bit FE = 1'b1;
  logic frame_err;
`else
  localparam bit FE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rx_en = 1'b0, rx_bit = 1'b1, rx_ren = 1'b0;
  logic [7:0] dout;
  logic empty, full, overrun, busy;
  int checks = 0, errors = 0, ferr_seen = 0, ferr_exp = 0;
  bit ovr_exp = 1'b0;
  logic [7:0] q[$];
  logic [7:0] vals[4] = '{8'h01, 8'h09, 8'h00, 8'h07};

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rx_en_i  (rx_en),
    .rx_bit_i (rx_bit),
    .rx_ren_i (rx_ren),
    .dout_o   (dout),
    .empty_o  (empty),
    .full_o   (full),
    .overrun_o(overrun),
    .busy_o   (busy)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err_o(frame_err)
`endif
  );

  always #5 clk = ~clk;

`ifdef UART_RX_FRAME_ERR_EN
  always @(posedge clk) if (frame_err) ferr_seen++;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ".empty"}, empty, q.size() == 0);
    check({tag, ".full"}, full, q.size() == DEPTH);
    check({tag, ".overrun"}, overrun, ovr_exp);
    check({tag, ".dout"}, dout, q.size() != 0 ? q[0] : 8'h00);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".dout"}, dout, 0);
    check({tag, ".empty"}, empty, 1);
    check({tag, ".full"}, full, 0);
    check({tag, ".overrun"}, overrun, 0);
    check({tag, ".busy"}, busy, 0);
  endtask

  // drive one frame LSB first, BD clocks per bit; optionally drop rx_en at bit drop_at
  task automatic send(input logic [7:0] d, input logic stop, input int drop_at);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_bit = f[i];
      if (i == drop_at) rx_en = 1'b0;
      repeat (BD) @(negedge clk);
    end
    rx_bit = 1'b1;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input int drop_at);
    logic acc;
    acc = rx_en;
    send(d, stop, drop_at);
    if (!stop) repeat (2 * BD) @(negedge clk);
    if (acc && (stop || !FE)) begin
      if (q.size() == DEPTH) ovr_exp = 1'b1;
      else q.push_back(d);
    end
    if (acc && !stop && FE) ferr_exp++;
    check("frame.busy", busy, 0);
    check_flags("frame");
  endtask

  task automatic pop_one();
    check_flags("pre_pop");
    rx_ren = 1'b1;
    @(negedge clk);
    rx_ren = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_flags("post_pop");
  endtask

  task automatic pop_all();
    while (q.size() != 0) pop_one();
    pop_one();
  endtask

  task automatic random_round(input int rounds);
    int n;
    logic stop;
    for (int r = 0; r < rounds; r++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        stop = $urandom_range(0, 3) != 0;
        frame(8'($urandom), stop, -1);
        repeat ($urandom_range(0, BD)) @(negedge clk);
      end
      pop_all();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("in_reset");
    rst_n = 1'b1;
    rx_en = 1'b1;
    @(negedge clk);
    check_reset("after_reset");
    // in-order delivery of a short burst
    foreach (vals[i]) frame(vals[i], 1'b1, -1);
    pop_all();
    // short low glitch must not start a frame
    rx_bit = 1'b0;
    repeat (BD / 2 - 3) @(negedge clk);
    check("glitch.busy_hi", busy, 1);
    rx_bit = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check("glitch.busy_lo", busy, 0);
    check_flags("glitch");
    // bad stop bit
    frame(8'hA5, 1'b0, -1);
    check("ferr.count", ferr_seen, ferr_exp);
    pop_all();
    // enable gating, and mid-frame disable has no effect
    rx_en = 1'b0;
    frame(8'h3C, 1'b1, -1);
    rx_en = 1'b1;
    frame(8'h3C, 1'b1, -1);
    frame(8'h96, 1'b1, 3);
    check("drop.en_low", rx_en, 0);
    frame(8'h11, 1'b1, -1);
    rx_en = 1'b1;
    pop_all();
    random_round(4);
    // fill, overflow, drain
    for (int i = 0; i < 17; i++) frame(8'(i), 1'b1, -1);
    check("fill.overrun", overrun, 1);
    pop_all();
    random_round(2);
    // reset in the middle of bit 4 of 'hFF, with a word still queued
    frame(8'h42, 1'b1, -1);
    rx_bit = 1'b0;
    repeat (BD) @(negedge clk);
    rx_bit = 1'b1;
    repeat (4 * BD + BD / 2) @(negedge clk);
    check("midframe.busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    q.delete();
    ovr_exp = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check_reset("post_abort");
    frame(8'h55, 1'b1, -1);
    pop_all();
    random_round(2);
    check("ferr.final", ferr_seen, ferr_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
